// File: rtl/ssd_pkg.sv
// ----------------------------------------------------------------------------
// ssd_pkg
// Shared constants for the seven-segment display driver.
//   SEG_BLANK  : all segments off (active-low bus)
//   SEG_TABLE  : hex digit -> active-low segment pattern
//   SEG_x      : bit position of each segment in the 7-bit bus (g..a = 6..0)
// ----------------------------------------------------------------------------
package ssd_pkg;

   // Segment bit order on the cathode bus: bit 6 = g ... bit 0 = a.
   localparam int SEG_A = 0;
   localparam int SEG_B = 1;
   localparam int SEG_C = 2;
   localparam int SEG_D = 3;
   localparam int SEG_E = 4;
   localparam int SEG_F = 5;
   localparam int SEG_G = 6;

   localparam logic [6:0] SEG_BLANK = 7'h7F;

   // Active-low patterns, a segment is lit when its bit is 0.
   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30,   // 0 1 2 3
      7'h19, 7'h12, 7'h02, 7'h78,   // 4 5 6 7
      7'h00, 7'h10, 7'h08, 7'h03,   // 8 9 A b
      7'h46, 7'h21, 7'h06, 7'h0E    // C d E F
   };

endpackage

// File: rtl/ssd_hex_decode.sv
// ----------------------------------------------------------------------------
// ssd_hex_decode
// Combinational 4-bit hex to 7-segment (active-low) decoder.
//   i_nib : hex nibble
//   o_seg : segments g..a, active-low
// ----------------------------------------------------------------------------
module ssd_hex_decode
   import ssd_pkg::*;
(
   input  logic [3:0] i_nib,
   output logic [6:0] o_seg
);

   assign o_seg = SEG_TABLE[i_nib];

endmodule

// File: rtl/ssd_mux_driver.sv
// ----------------------------------------------------------------------------
// ssd_mux_driver
// Time-multiplexed common-anode seven-segment driver with refresh prescaler,
// frame-synchronous double buffering, per-digit enable, decimal points,
// blinking and leading-zero suppression.
//   ssd_clk               : clock
//   ssd_rst               : synchronous active-high reset
//   ssd_driver_port_inp   : packed hex value, nibble k = digit k (0 = rightmost)
//   ssd_driver_port_en    : per-digit enable (0 = blanked)
//   ssd_driver_port_dp    : per-digit decimal point request
//   ssd_driver_port_blink : per-digit blink select
//   ssd_driver_port_lz    : leading-zero suppression enable
//   ssd_driver_port_load  : capture strobe into the pending bank
//   ssd_driver_port_cc    : segments g..a, active-low
//   ssd_driver_port_dpo   : decimal point, active-low
//   ssd_driver_port_an    : anodes, one-hot active-low
//   ssd_driver_port_frame : one-cycle pulse at each frame start
// ----------------------------------------------------------------------------
module ssd_mux_driver
   import ssd_pkg::*;
#(
   parameter int NUM_DIGITS   = 8,
   parameter int PRESCALE     = 100000,
   parameter int BLINK_FRAMES = 64
)
(
   input  logic                    ssd_clk,
   input  logic                    ssd_rst,
   input  logic [4*NUM_DIGITS-1:0] ssd_driver_port_inp,
   input  logic [NUM_DIGITS-1:0]   ssd_driver_port_en,
   input  logic [NUM_DIGITS-1:0]   ssd_driver_port_dp,
   input  logic [NUM_DIGITS-1:0]   ssd_driver_port_blink,
   input  logic                    ssd_driver_port_lz,
   input  logic                    ssd_driver_port_load,
   output logic [6:0]              ssd_driver_port_cc,
   output logic                    ssd_driver_port_dpo,
   output logic [NUM_DIGITS-1:0]   ssd_driver_port_an,
   output logic                    ssd_driver_port_frame
);

   localparam int IDX_W = $clog2(NUM_DIGITS);
   localparam int PRE_W = $clog2(PRESCALE);
   localparam int FC_W  = $clog2(BLINK_FRAMES + 1);

   localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
   localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(PRESCALE - 1);
   localparam logic [FC_W-1:0]       FC_LAST  = FC_W'(BLINK_FRAMES - 1);
   localparam logic [NUM_DIGITS-1:0] AN_ONE   = {{(NUM_DIGITS-1){1'b0}}, 1'b1};

   // Timing state
   logic [PRE_W-1:0]      r_pre;
   logic [IDX_W-1:0]      r_idx;
   logic [FC_W-1:0]       r_fcnt;
   logic                  r_phase;       // phase for the next frame to start
   logic                  r_disp_phase;  // phase of the frame on display

   // Pending bank (written by load)
   logic [4*NUM_DIGITS-1:0] r_pend_inp;
   logic [NUM_DIGITS-1:0]   r_pend_en;
   logic [NUM_DIGITS-1:0]   r_pend_dp;
   logic [NUM_DIGITS-1:0]   r_pend_blink;
   logic                    r_pend_lz;

   // Active bank (drives the display)
   logic [4*NUM_DIGITS-1:0] r_act_inp;
   logic [NUM_DIGITS-1:0]   r_act_en;
   logic [NUM_DIGITS-1:0]   r_act_dp;
   logic [NUM_DIGITS-1:0]   r_act_blink;
   logic                    r_act_lz;

   // Output registers
   logic [NUM_DIGITS-1:0] r_an;
   logic [6:0]            r_cc;
   logic                  r_dpo;
   logic                  r_frame;

   logic                    w_tick;
   logic                    w_fs;
   logic [IDX_W-1:0]        w_idx_nxt;
   logic [4*NUM_DIGITS-1:0] w_sel_inp;
   logic [NUM_DIGITS-1:0]   w_sel_en;
   logic [NUM_DIGITS-1:0]   w_sel_dp;
   logic [NUM_DIGITS-1:0]   w_sel_blink;
   logic                    w_sel_lz;
   logic                    w_phase;
   logic [4*NUM_DIGITS-1:0] w_upper;
   logic [3:0]              w_nib;
   logic                    w_lz_hit;
   logic                    w_blank;
   logic [6:0]              w_seg;

   assign w_tick    = (r_pre == PRE_LAST);
   assign w_fs      = w_tick && (r_idx == IDX_LAST);
   assign w_idx_nxt = (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;

   // The slot computed on a frame-start edge belongs to the new frame, so it
   // must see the bank and blink phase that are being promoted on that edge.
   assign w_sel_inp   = w_fs ? r_pend_inp   : r_act_inp;
   assign w_sel_en    = w_fs ? r_pend_en    : r_act_en;
   assign w_sel_dp    = w_fs ? r_pend_dp    : r_act_dp;
   assign w_sel_blink = w_fs ? r_pend_blink : r_act_blink;
   assign w_sel_lz    = w_fs ? r_pend_lz    : r_act_lz;
   assign w_phase     = w_fs ? r_phase      : r_disp_phase;

   // After shifting, the remaining value is zero exactly when this digit and
   // every digit to its left are zero.
   assign w_upper  = w_sel_inp >> {w_idx_nxt, 2'b00};
   assign w_nib    = w_upper[3:0];
   assign w_lz_hit = w_sel_lz && (w_idx_nxt != '0) && (w_upper == '0);
   assign w_blank  = !w_sel_en[w_idx_nxt]
                     || (w_sel_blink[w_idx_nxt] && w_phase)
                     || w_lz_hit;

   ssd_hex_decode u_dec (
      .i_nib (w_nib),
      .o_seg (w_seg)
   );

   always_ff @(posedge ssd_clk) begin
      if (ssd_rst) begin
         r_pre        <= '0;
         r_idx        <= IDX_LAST;
         r_fcnt       <= '0;
         r_phase      <= 1'b0;
         r_disp_phase <= 1'b0;
         r_pend_inp   <= '0;
         r_pend_en    <= '0;
         r_pend_dp    <= '0;
         r_pend_blink <= '0;
         r_pend_lz    <= 1'b0;
         r_act_inp    <= '0;
         r_act_en     <= '0;
         r_act_dp     <= '0;
         r_act_blink  <= '0;
         r_act_lz     <= 1'b0;
         r_an         <= '1;
         r_cc         <= SEG_BLANK;
         r_dpo        <= 1'b1;
         r_frame      <= 1'b0;
      end else begin
         r_frame <= w_fs;
         r_pre   <= w_tick ? '0 : r_pre + 1'b1;

         if (ssd_driver_port_load) begin
            r_pend_inp   <= ssd_driver_port_inp;
            r_pend_en    <= ssd_driver_port_en;
            r_pend_dp    <= ssd_driver_port_dp;
            r_pend_blink <= ssd_driver_port_blink;
            r_pend_lz    <= ssd_driver_port_lz;
         end

         if (w_tick) begin
            r_idx <= w_idx_nxt;
            if (w_blank) begin
               r_an  <= '1;
               r_cc  <= SEG_BLANK;
               r_dpo <= 1'b1;
            end else begin
               r_an  <= ~(AN_ONE << w_idx_nxt);
               r_cc  <= w_seg;
               r_dpo <= ~w_sel_dp[w_idx_nxt];
            end
         end

         if (w_fs) begin
            r_act_inp    <= r_pend_inp;
            r_act_en     <= r_pend_en;
            r_act_dp     <= r_pend_dp;
            r_act_blink  <= r_pend_blink;
            r_act_lz     <= r_pend_lz;
            r_disp_phase <= r_phase;
            if (r_fcnt == FC_LAST) begin
               r_fcnt  <= '0;
               r_phase <= ~r_phase;
            end else begin
               r_fcnt <= r_fcnt + 1'b1;
            end
         end
      end
   end

   assign ssd_driver_port_an    = r_an;
   assign ssd_driver_port_cc    = r_cc;
   assign ssd_driver_port_dpo   = r_dpo;
   assign ssd_driver_port_frame = r_frame;

endmodule

// File: tb/tb_ssd_mux_driver.sv
// ----------------------------------------------------------------------------
// tb_ssd_mux_driver
// Bench for ssd_mux_driver with NUM_DIGITS=4, PRESCALE=4, BLINK_FRAMES=2.
// The model tracks edges since reset and derives slot, frame and blink phase
// from that count; pending/active banks are copied at frame starts.
// ----------------------------------------------------------------------------
module tb_ssd_mux_driver;

   localparam int N  = 4;
   localparam int P  = 4;
   localparam int BF = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic [15:0]  inp = '0;
   logic [3:0]   en = '0, dp = '0, blink = '0;
   logic         lz = 1'b0, load = 1'b0;
   logic [6:0]   cc;
   logic         dpo, frame;
   logic [3:0]   an;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   ssd_mux_driver #(.NUM_DIGITS(N), .PRESCALE(P), .BLINK_FRAMES(BF)) dut (
      .ssd_clk               (clk),
      .ssd_rst               (rst),
      .ssd_driver_port_inp   (inp),
      .ssd_driver_port_en    (en),
      .ssd_driver_port_dp    (dp),
      .ssd_driver_port_blink (blink),
      .ssd_driver_port_lz    (lz),
      .ssd_driver_port_load  (load),
      .ssd_driver_port_cc    (cc),
      .ssd_driver_port_dpo   (dpo),
      .ssd_driver_port_an    (an),
      .ssd_driver_port_frame (frame)
   );

   // Independent hex table for the model.
   logic [6:0] hex_tbl [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
   };

   // ---------------- behavioural model ----------------
   int          m_e = 0;
   bit          m_valid = 1'b0;
   logic [15:0] p_inp, a_inp;
   logic [3:0]  p_en, p_dp, p_bl, a_en, a_dp, a_bl;
   logic        p_lz, a_lz;

   always @(posedge clk) begin
      if (rst) begin
         m_e = 0;
         p_inp = '0; p_en = '0; p_dp = '0; p_bl = '0; p_lz = 1'b0;
         a_inp = '0; a_en = '0; a_dp = '0; a_bl = '0; a_lz = 1'b0;
         m_valid = 1'b1;
      end else if (m_valid) begin
         m_e++;
         if (m_e >= P && ((m_e - P) % (N * P)) == 0) begin
            a_inp = p_inp; a_en = p_en; a_dp = p_dp; a_bl = p_bl; a_lz = p_lz;
         end
         if (load) begin
            p_inp = inp; p_en = en; p_dp = dp; p_bl = blink; p_lz = lz;
         end
      end
   end

   logic [3:0] x_an;
   logic [6:0] x_cc;
   logic       x_dpo, x_fr;

   task automatic model_out();
      int  s, f, idx;
      bit  phase, zero_above, blank;
      x_an = 4'hF; x_cc = 7'h7F; x_dpo = 1'b1; x_fr = 1'b0;
      if (m_e >= P) begin
         s     = (m_e - P) / P;
         f     = s / N;
         idx   = s % N;
         x_fr  = ((m_e - P) % (N * P)) == 0;
         phase = ((f / BF) % 2) == 1;
         zero_above = 1'b1;
         for (int k = idx; k < N; k++)
            if (a_inp[k*4 +: 4] != 4'h0) zero_above = 1'b0;
         blank = !a_en[idx] || (a_bl[idx] && phase) || (a_lz && idx != 0 && zero_above);
         if (!blank) begin
            x_an  = ~(4'b0001 << idx);
            x_cc  = hex_tbl[a_inp[idx*4 +: 4]];
            x_dpo = ~a_dp[idx];
         end
      end
   endtask

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (m_valid) begin
         model_out();
         checks++;
         if (an !== x_an || cc !== x_cc || dpo !== x_dpo || frame !== x_fr) begin
            failures++;
            $display("FAIL cycle_model e=%0d actual an=%b cc=%b dpo=%b frame=%b required an=%b cc=%b dpo=%b frame=%b",
                     m_e, an, cc, dpo, frame, x_an, x_cc, x_dpo, x_fr);
         end
      end
   end

   // ---------------- directed stimulus ----------------
   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s e=%0d actual=%h required=%h", name, m_e, act, exp);
      end
   endtask

   task automatic step_to(input int target);
      while (m_e < target) begin
         @(posedge clk);
         #1;
      end
      if (m_e != target) begin
         checks++;
         failures++;
         $display("FAIL step_to actual=%0d required=%0d", m_e, target);
      end
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   task automatic do_load(input int at_edge, input logic [15:0] v, input logic [3:0] e,
                          input logic [3:0] d, input logic [3:0] b, input logic z);
      step_to(at_edge - 1);
      inp = v; en = e; dp = d; blink = b; lz = z; load = 1'b1;
      step_to(at_edge);
      load = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_an", {4'h0, an}, 8'h0F);
      chk("rst_cc", {1'b0, cc}, 8'h7F);
      chk("rst_dpo", {7'h0, dpo}, 8'h01);
      chk("rst_frame", {7'h0, frame}, 8'h00);

      // Scan sequence with all digits enabled
      do_load(1, 16'h0000, 4'hF, 4'h0, 4'h0, 1'b0);
      step_to(3);  chk("pre_tick_an", {4'h0, an}, 8'h0F);
      step_to(4);  chk("slot0_an", {4'h0, an}, 8'h0E); chk("frame_first", {7'h0, frame}, 8'h01);
      step_to(5);  chk("frame_one_cycle", {7'h0, frame}, 8'h00);
      do_load(6, 16'h12AF, 4'hF, 4'h0, 4'h0, 1'b0);
      step_to(7);  chk("slot0_hold", {4'h0, an}, 8'h0E);
      step_to(8);  chk("slot1_an", {4'h0, an}, 8'h0D);
      step_to(12); chk("slot2_an", {4'h0, an}, 8'h0B);
      step_to(16); chk("slot3_an", {4'h0, an}, 8'h07);

      // 12AF visible from frame 1
      step_to(20); chk("f1_cc_F", {1'b0, cc}, 8'h0E); chk("f1_frame", {7'h0, frame}, 8'h01);
      step_to(24); chk("f1_cc_A", {1'b0, cc}, 8'h08);
      step_to(28); chk("f1_cc_2", {1'b0, cc}, 8'h24);
      step_to(32); chk("f1_cc_1", {1'b0, cc}, 8'h79);

      // Mid-frame load does not disturb the current frame
      do_load(38, 16'h0000, 4'hF, 4'h0, 4'h0, 1'b0);
      step_to(40); chk("midload_old", {1'b0, cc}, 8'h08);
      step_to(52); chk("midload_new", {1'b0, cc}, 8'h40);

      // Load on frame-start edge is delayed a frame
      do_load(68, 16'h1234, 4'hF, 4'h0, 4'h0, 1'b0);
      chk("fsload_old", {1'b0, cc}, 8'h40);
      step_to(84); chk("fsload_new", {1'b0, cc}, 8'h19);

      // Leading-zero suppression
      do_load(90, 16'h0050, 4'hF, 4'h0, 4'h0, 1'b1);
      step_to(100); chk("lz_d0_an", {4'h0, an}, 8'h0E); chk("lz_d0_cc", {1'b0, cc}, 8'h40);
      step_to(104); chk("lz_d1_an", {4'h0, an}, 8'h0D); chk("lz_d1_cc", {1'b0, cc}, 8'h12);
      step_to(108); chk("lz_d2_an", {4'h0, an}, 8'h0F); chk("lz_d2_cc", {1'b0, cc}, 8'h7F);
      step_to(112); chk("lz_d3_an", {4'h0, an}, 8'h0F);
      do_load(118, 16'h0000, 4'hF, 4'h0, 4'h0, 1'b1);
      step_to(132); chk("lz0_d0_an", {4'h0, an}, 8'h0E); chk("lz0_d0_cc", {1'b0, cc}, 8'h40);
      step_to(136); chk("lz0_d1_an", {4'h0, an}, 8'h0F);

      // Blink and decimal point, fresh frame numbering
      do_reset();
      do_load(1, 16'h0000, 4'hF, 4'b0010, 4'b0001, 1'b0);
      step_to(4);  chk("bl_f0_an", {4'h0, an}, 8'h0E); chk("bl_f0_dpo", {7'h0, dpo}, 8'h01);
      step_to(8);  chk("dp_d1_dpo", {7'h0, dpo}, 8'h00);
      step_to(12); chk("dp_d2_dpo", {7'h0, dpo}, 8'h01);
      step_to(20); chk("bl_f1_an", {4'h0, an}, 8'h0E);
      step_to(36); chk("bl_f2_an", {4'h0, an}, 8'h0F); chk("bl_f2_cc", {1'b0, cc}, 8'h7F);
      step_to(40); chk("bl_f2_d1", {4'h0, an}, 8'h0D); chk("bl_f2_dpo", {7'h0, dpo}, 8'h00);
      step_to(52); chk("bl_f3_an", {4'h0, an}, 8'h0F);
      step_to(68); chk("bl_f4_an", {4'h0, an}, 8'h0E);
      step_to(84); chk("bl_f5_an", {4'h0, an}, 8'h0E);

      // Mid-slot reset with load asserted
      step_to(89);
      rst = 1'b1; load = 1'b1; inp = 16'hFFFF; en = 4'hF; dp = 4'hF; blink = 4'h0;
      @(posedge clk); #1;
      chk("mrst_an", {4'h0, an}, 8'h0F);
      chk("mrst_cc", {1'b0, cc}, 8'h7F);
      chk("mrst_dpo", {7'h0, dpo}, 8'h01);
      chk("mrst_frame", {7'h0, frame}, 8'h00);
      @(posedge clk); #1;
      rst = 1'b0; load = 1'b0;
      step_to(3); chk("mrst_pre_tick", {7'h0, frame}, 8'h00);
      step_to(4); chk("mrst_tick_frame", {7'h0, frame}, 8'h01); chk("mrst_pend_clr", {4'h0, an}, 8'h0F);
      do_load(5, 16'h0000, 4'hF, 4'h0, 4'h0, 1'b0);
      step_to(20); chk("mrst_f1_an", {4'h0, an}, 8'h0E); chk("mrst_f1_cc", {1'b0, cc}, 8'h40);

      step_to(24);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ssd_mux_driver.md
# ssd_mux_driver

Parametrised time-multiplexed seven-segment display driver for common-anode boards: drives NUM_DIGITS hex digits from one packed value through a shared active-low cathode bus and one-hot active-low anodes. It adds features the two-digit driver lacks: an internal refresh prescaler, frame-synchronous double-buffered loading, per-digit enable, decimal points, blinking and leading-zero suppression. It sits between register-mapped display data and the board SSD pins.

## Interface
- NUM_DIGITS, 8, digit count (2..16)
- PRESCALE, 100000, ssd_clk cycles per digit slot (≥2)
- BLINK_FRAMES, 64, frames per blink half-period (≥1)
- ssd_clk  in  1  sole clock
- ssd_rst  in  1  reset; one clock, synchronous and active-high
- ssd_driver_port_inp  in  4*NUM_DIGITS  hex value; nibble k = digit k, digit 0 = rightmost
- ssd_driver_port_en  in  NUM_DIGITS  per-digit enable (0 = blanked)
- ssd_driver_port_dp  in  NUM_DIGITS  per-digit decimal point request (1 = lit)
- ssd_driver_port_blink  in  NUM_DIGITS  per-digit blink select
- ssd_driver_port_lz  in  1  leading-zero suppression enable
- ssd_driver_port_load  in  1  capture strobe for inp/en/dp/blink/lz
- ssd_driver_port_cc  out  7  segments g..a, active-low
- ssd_driver_port_dpo  out  1  decimal point, active-low
- ssd_driver_port_an  out  NUM_DIGITS  anodes, one-hot active-low
- ssd_driver_port_frame  out  1  one-cycle pulse at each frame start

## Operation
- Two register banks: pending (written by load) and active (drives display). load=1 at an edge captures all data inputs into pending.
- Prescaler counts 0..PRESCALE-1; tick asserted when count = PRESCALE-1, count then wraps to 0.
- Digit index idx: on tick, idx ← (idx = NUM_DIGITS-1) ? 0 : idx+1. Wrap to 0 is a frame start: active ← pending, frame pulses, blink frame counter advances.
- Blink: frame counter counts 0..BLINK_FRAMES-1; on its wrap, blink phase toggles. Phase 1 blanks every digit with blink bit set.
- Leading-zero suppression (active lz=1): digit k blanked when all nibbles k..NUM_DIGITS-1 are 0 and k ≠ 0; digit 0 never suppressed. Decimal point of a suppressed digit also off.
- Digit k displayed blank when en[k]=0, or blink-blanked, or LZ-suppressed: an all ones, cc = 7'h7F, dpo = 1.
- Otherwise an = ~(1<<idx), cc = hex decode of active nibble idx (0→7'b1000000 … F→7'b0001110, standard table), dpo = ~dp[idx].
- All outputs registered; an, cc, dpo always change on the same edge (no ghosting between slot and segments).

## Timing
- Reset values: an all ones, cc 7'h7F, dpo 1, frame 0; idx = NUM_DIGITS-1, prescaler 0, pending/active cleared (inp 0, en 0, dp 0, blink 0, lz 0), blink phase 0, frame counter 0.
- First tick occurs PRESCALE cycles after reset deasserts; it starts frame 0 and displays digit 0.
- Outputs update on the tick edge; each slot lasts exactly PRESCALE cycles; frame = NUM_DIGITS·PRESCALE cycles.
- Load latency to display: captured next edge, visible from next frame start.
- load coincident with frame-start tick: active takes the old pending; new data shows one frame later.
- Multiple loads in one frame: last wins.
- ssd_rst mid-frame: all state returns to reset values on that edge regardless of load/tick; reset overrides.

## Structure
- Package ssd_pkg: SEG_BLANK = 7'h7F, 16-entry hex-to-segment constant table, segment bit-order definition.
- Sub-module ssd_hex_decode: combinational 4-bit → 7-bit active-low decoder using the package table; one instance on the muxed nibble.

## Test plan
- NUM_DIGITS=4, PRESCALE=4: reset then run 16 cycles → an sequence 1110,1101,1011,0111 each held 4 cycles, frame pulse once at first tick; reset outputs an=1111, cc=7F.
- load inp=16'h12AF, en=1111 → from next frame cc per slot = 0001110, 0001000, 0100100, 1111001 (F, A, 2, 1).
- Pending/active: load 16'h0000 mid-frame → current frame still shows old value; change visible exactly at next frame pulse; load on frame-start edge → delayed one extra frame.
- lz=1, inp=16'h0050 → digits 3 blank (an 1111 in its slot), 2 blank, 1 shows 5, 0 shows 0; inp=0 → only digit 0 lit showing 0.
- BLINK_FRAMES=2, blink=0001, dp=0010 → digit 0 blank frames 2-3, lit 0-1 and 4-5; dpo=0 only in digit-1 slot.
- Assert ssd_rst mid-slot with load high → next edge all outputs reset values, pending cleared, restart timing identical to power-up.
